// File: rtl/svn_seg_scan_decoder.sv
// Readback decoder for the 3-digit multiplexed 7-segment bus: debounces each digit dwell,
// decodes the glyph to hex and publishes a 12-bit word once all three digits are seen.
module svn_seg_scan_decoder #(
  parameter int STABLE_CYC = 16,
  parameter int TIMEOUT    = 262143,
  parameter int TO_W       = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  en,
  input  logic [6:0]  svn_conf,
  input  logic        DP,
  output logic [11:0] data,
  output logic [2:0]  dp_mask,
  output logic        frame_valid,
  output logic        seg_err,
  output logic        stale
);

  localparam int CW = $clog2(STABLE_CYC) + 1;

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [11:0]     smp_reg, prev_reg;
  logic [TO_W-1:0] to_cnt_reg;
  logic [2:0]      mask_reg, mask_next;
  logic [11:0]     nib_reg, nib_next;
  logic [2:0]      dpb_reg, dpb_next;
  logic            change, capture, good_cap, frame_done;
  logic [2:0]      slot_sel;
  logic            is_blank, glyph_ok;
  logic [3:0]      glyph_code;

  function automatic logic [4:0] glyph_dec(input logic [6:0] s);
    case (s)
      7'h40: glyph_dec = {1'b1, 4'h0};
      7'h79: glyph_dec = {1'b1, 4'h1};
      7'h24: glyph_dec = {1'b1, 4'h2};
      7'h30: glyph_dec = {1'b1, 4'h3};
      7'h19: glyph_dec = {1'b1, 4'h4};
      7'h12: glyph_dec = {1'b1, 4'h5};
      7'h02: glyph_dec = {1'b1, 4'h6};
      7'h78: glyph_dec = {1'b1, 4'h7};
      7'h00: glyph_dec = {1'b1, 4'h8};
      7'h10: glyph_dec = {1'b1, 4'h9};
      7'h08: glyph_dec = {1'b1, 4'hA};
      7'h03: glyph_dec = {1'b1, 4'hB};
      7'h46: glyph_dec = {1'b1, 4'hC};
      7'h21: glyph_dec = {1'b1, 4'hD};
      7'h06: glyph_dec = {1'b1, 4'hE};
      7'h0E: glyph_dec = {1'b1, 4'hF};
      default: glyph_dec = {1'b0, 4'h0};
    endcase
  endfunction

  // Bus idles as all-ones (no digit, segments dark), so that is the reset sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      smp_reg  <= '1;
      prev_reg <= '1;
    end else begin
      smp_reg  <= {en, svn_conf, DP};
      prev_reg <= smp_reg;
    end
  end

  assign change = (smp_reg != prev_reg);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (change) begin
          state_next = SETTLE;
          cnt_next   = CW'(1);
        end
      end
      SETTLE: begin
        if (change) begin
          cnt_next = CW'(1);
        end else if (cnt_reg == CW'(STABLE_CYC)) begin
          capture    = 1'b1;
          state_next = HOLD;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      HOLD: begin
        if (change) begin
          state_next = SETTLE;
          cnt_next   = CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    slot_sel = 3'b000;
    is_blank = 1'b0;
    case (smp_reg[11:8])
      4'b1110: slot_sel = 3'b001;
      4'b1101: slot_sel = 3'b010;
      4'b1011: slot_sel = 3'b100;
      4'b1111: is_blank = 1'b1;
      default: slot_sel = 3'b000;
    endcase
  end

  assign {glyph_ok, glyph_code} = glyph_dec(smp_reg[7:1]);
  assign good_cap   = capture && (slot_sel != 3'b000) && glyph_ok;
  assign mask_next  = mask_reg | (good_cap ? slot_sel : 3'b000);
  assign frame_done = good_cap && (mask_next == 3'b111);

  // Next slot contents let the completing digit land in data on the same edge it is stored.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_slot
      assign nib_next[gi*4 +: 4] = (good_cap && slot_sel[gi]) ? glyph_code : nib_reg[gi*4 +: 4];
      assign dpb_next[gi]        = (good_cap && slot_sel[gi]) ? smp_reg[0] : dpb_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      to_cnt_reg  <= '0;
      mask_reg    <= '0;
      nib_reg     <= '0;
      dpb_reg     <= '0;
      data        <= '0;
      dp_mask     <= '0;
      frame_valid <= 1'b0;
      seg_err     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      nib_reg     <= nib_next;
      dpb_reg     <= dpb_next;
      frame_valid <= frame_done;
      if (frame_done) begin
        data     <= nib_next;
        dp_mask  <= dpb_next;
        mask_reg <= 3'b000;
      end else begin
        mask_reg <= mask_next;
      end
      if (capture && !is_blank && ((slot_sel == 3'b000) || !glyph_ok))
        seg_err <= 1'b1;
      if (good_cap)
        to_cnt_reg <= '0;
      else if (to_cnt_reg != TO_W'(TIMEOUT))
        to_cnt_reg <= to_cnt_reg + TO_W'(1);
    end
  end

  assign stale = (to_cnt_reg == TO_W'(TIMEOUT));

endmodule

// File: tb/tb_svn_seg_scan_decoder.sv
// Directed bench for svn_seg_scan_decoder: scans, glitches, bad codes, timeout and reset.
module tb_svn_seg_scan_decoder;

  localparam int STABLE_CYC = 16;
  localparam int TIMEOUT    = 300;
  localparam int TO_W       = 9;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  en;
  logic [6:0]  svn_conf;
  logic        DP;
  logic [11:0] data;
  logic [2:0]  dp_mask;
  logic        frame_valid;
  logic        seg_err;
  logic        stale;

  int n_checks = 0;
  int n_errors = 0;
  int fv_count = 0;
  int fv_base;

  svn_seg_scan_decoder #(
    .STABLE_CYC(STABLE_CYC),
    .TIMEOUT(TIMEOUT),
    .TO_W(TO_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .svn_conf(svn_conf),
    .DP(DP),
    .data(data),
    .dp_mask(dp_mask),
    .frame_valid(frame_valid),
    .seg_err(seg_err),
    .stale(stale)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_valid) fv_count++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+2; returns at posedge+2 after n cycles.
  task automatic show(input logic [3:0] e, input logic [6:0] s, input logic d, input int n);
    en = e; svn_conf = s; DP = d;
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 4'hF; svn_conf = 7'h7F; DP = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 4'hF; svn_conf = 7'h7F; DP = 1'b0;
    #2;
    do_reset();
    check("rst_data", data, 12'h000);
    check("rst_dp", dp_mask, 3'b000);
    check("rst_fv", frame_valid, 1'b0);
    check("rst_err", seg_err, 1'b0);
    check("rst_stale", stale, 1'b0);

    // 1: d0=3, d1=A (DP on), d2=F with exact latency on the completing digit
    fv_base = fv_count;
    show(4'b1110, 7'h30, 1'b0, 40);
    show(4'b1101, 7'h08, 1'b1, 40);
    check("t1_nofv_early", fv_count - fv_base, 0);
    en = 4'b1011; svn_conf = 7'h0E; DP = 1'b0;
    repeat (17) @(posedge clk); #2;
    check("t1_fv_before", frame_valid, 1'b0);
    @(posedge clk); #2;
    check("t1_fv_pulse", frame_valid, 1'b1);
    check("t1_data", data, 12'hFA3);
    check("t1_dp", dp_mask, 3'b010);
    @(posedge clk); #2;
    check("t1_fv_after", frame_valid, 1'b0);
    show(4'b1011, 7'h0E, 1'b0, 20);
    check("t1_fv_count", fv_count - fv_base, 1);
    $display("scan 1: data=%03h dp_mask=%03b", data, dp_mask);

    // 2: glyph glitch on d0 must not be captured
    do_reset();
    fv_base = fv_count;
    show(4'b1011, 7'h24, 1'b0, 40);
    show(4'b1101, 7'h79, 1'b0, 40);
    show(4'b1110, 7'h79, 1'b0, STABLE_CYC - 1);
    check("t2_glitch_nofv", fv_count - fv_base, 0);
    show(4'b1110, 7'h40, 1'b0, 40);
    check("t2_fv_count", fv_count - fv_base, 1);
    check("t2_data", data, 12'h210);
    check("t2_err", seg_err, 1'b0);
    $display("scan 2: data=%03h", data);

    // 3: illegal enable code, then a valid frame still lands
    do_reset();
    fv_base = fv_count;
    show(4'b0011, 7'h40, 1'b0, 100);
    check("t3_err_set", seg_err, 1'b1);
    check("t3_nofv", fv_count - fv_base, 0);
    show(4'b1110, 7'h79, 1'b0, 40);
    show(4'b1101, 7'h24, 1'b0, 40);
    show(4'b1011, 7'h30, 1'b0, 40);
    check("t3_err_sticky", seg_err, 1'b1);
    check("t3_fv_count", fv_count - fv_base, 1);
    check("t3_data", data, 12'h321);
    $display("scan 3: data=%03h seg_err=%0d", data, seg_err);

    // 4: unknown glyph on d1 blocks the frame until d1 is re-shown
    do_reset();
    check("t4_err_clr", seg_err, 1'b0);
    fv_base = fv_count;
    show(4'b1110, 7'h19, 1'b0, 40);
    show(4'b1101, 7'h7F, 1'b0, 40);
    show(4'b1011, 7'h12, 1'b1, 40);
    check("t4_err_set", seg_err, 1'b1);
    check("t4_nofv", fv_count - fv_base, 0);
    show(4'b1101, 7'h02, 1'b0, 40);
    check("t4_fv_count", fv_count - fv_base, 1);
    check("t4_data", data, 12'h564);
    check("t4_dp", dp_mask, 3'b100);
    $display("scan 4: data=%03h dp_mask=%03b", data, dp_mask);

    // 5: stale after TIMEOUT idle cycles, cleared by the next capture
    do_reset();
    show(4'b1111, 7'h7F, 1'b0, TIMEOUT - 20);
    check("t5_not_stale", stale, 1'b0);
    show(4'b1111, 7'h7F, 1'b0, 25);
    check("t5_stale", stale, 1'b1);
    show(4'b1110, 7'h00, 1'b0, 10);
    check("t5_stale_hold", stale, 1'b1);
    show(4'b1110, 7'h00, 1'b0, 10);
    check("t5_stale_clr", stale, 1'b0);
    $display("scan 5: stale=%0d", stale);

    // 6: reset mid-frame discards captured digits
    do_reset();
    fv_base = fv_count;
    show(4'b1110, 7'h79, 1'b0, 40);
    show(4'b1101, 7'h24, 1'b0, 40);
    do_reset();
    show(4'b1011, 7'h78, 1'b0, 40);
    check("t6_no_partial", fv_count - fv_base, 0);
    show(4'b1110, 7'h12, 1'b0, 40);
    show(4'b1101, 7'h02, 1'b0, 40);
    check("t6_fv_count", fv_count - fv_base, 1);
    check("t6_data", data, 12'h765);
    $display("scan 6: data=%03h", data);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
